// File: rtl/pipeline_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl_pkg
// Shared encodings for the 5-stage MIPS hazard logic: Tuse/Tnew codes, MD
// tracker state encoding, default MD latencies and the GPR hazard helper used
// by the stall decoder.
// Optional feature macro used elsewhere in this slice: STALL_STATS_EN.
// -----------------------------------------------------------------------------
package pipeline_stall_ctrl_pkg;

  // Tuse: cycles until the ID instruction consumes an operand; 3 = not used.
  localparam logic [1:0] TUSE_0    = 2'd0;
  localparam logic [1:0] TUSE_1    = 2'd1;
  localparam logic [1:0] TUSE_2    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Tnew: cycles until a producer's result can be forwarded.
  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  // Default multi-cycle MD unit latencies.
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // A source operand must wait when a younger-stage producer writes the same
  // non-zero register and its result arrives later than the operand is needed.
  // TUSE_NONE can never lose this comparison since Tnew tops out at 2.
  function automatic logic gpr_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] dst_e,
    input logic [1:0] tnew_e,
    input logic [4:0] dst_m,
    input logic [1:0] tnew_m
  );
    logic hit_e;
    logic hit_m;
    hit_e = (src == dst_e) && (tnew_e > tuse);
    hit_m = (src == dst_m) && (tnew_m > tuse);
    return (src != 5'd0) && (hit_e || hit_m);
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl_if
// Bundles the hazard-detection signals between the pipeline datapath and the
// stall controller.
//   master : pipeline side -- drives ID/EX/MEM hazard info, receives enables
//   slave  : stall controller -- receives hazard info, drives enables/md_busy
// Signals:
//   rs_d, rt_d, tuse_rs_d, tuse_rt_d, md_use_d   ID-stage operand usage
//   dst_e, tnew_e, dst_m, tnew_m                 EX/MEM producers
//   md_start_e, md_div_e                         MD op start pulse + kind
//   en_pc, en_if_id, flush_id_ex, md_busy        controller outputs
// -----------------------------------------------------------------------------
interface pipeline_stall_ctrl_if;

  logic [4:0] rs_d;
  logic [4:0] rt_d;
  logic [1:0] tuse_rs_d;
  logic [1:0] tuse_rt_d;
  logic       md_use_d;
  logic [4:0] dst_e;
  logic [1:0] tnew_e;
  logic [4:0] dst_m;
  logic [1:0] tnew_m;
  logic       md_start_e;
  logic       md_div_e;
  logic       en_pc;
  logic       en_if_id;
  logic       flush_id_ex;
  logic       md_busy;

  modport master (
    output rs_d, rt_d, tuse_rs_d, tuse_rt_d, md_use_d,
    output dst_e, tnew_e, dst_m, tnew_m, md_start_e, md_div_e,
    input  en_pc, en_if_id, flush_id_ex, md_busy
  );

  modport slave (
    input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, md_use_d,
    input  dst_e, tnew_e, dst_m, tnew_m, md_start_e, md_div_e,
    output en_pc, en_if_id, flush_id_ex, md_busy
  );

endinterface

// File: rtl/pipeline_stall_ctrl_md_busy_tracker.sv
// -----------------------------------------------------------------------------
// md_busy_tracker
// Tracks the multi-cycle mult/div unit. A start pulse loads a countdown with
// the op latency; md_busy is high for exactly that many cycles beginning the
// cycle after the pulse. Starts seen while busy are ignored (the pipeline
// stalls the MD instruction in ID, so none should arrive).
// Ports:
//   clk      in  clock
//   reset    in  synchronous active-high; abandons any op in flight
//   md_start in  one-cycle start pulse from EX
//   md_div   in  1 = div/divu latency, 0 = mult/multu latency
//   md_busy  out registered busy flag
// -----------------------------------------------------------------------------
module md_busy_tracker
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  input  logic md_div,
  output logic md_busy
);

  md_state_e        state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= MD_IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        MD_IDLE: begin
          if (md_start) begin
            state_reg <= MD_BUSY;
            cnt_reg   <= md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            busy_reg  <= 1'b1;
          end
        end
        MD_BUSY: begin
          // cnt_reg holds the busy cycles remaining including this one.
          if (cnt_reg == CNT_W'(1)) begin
            state_reg <= MD_IDLE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign md_busy = busy_reg;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl
// Hazard/stall controller for the 5-stage MIPS pipeline. Decodes, in the same
// cycle, GPR RAW hazards (Tuse/Tnew rule against EX and MEM producers) and
// MD-unit structural hazards, and drives PC enable, IF/ID enable and ID/EX
// flush. The MD busy countdown lives in md_busy_tracker.
// Ports:
//   clk          in   clock
//   reset        in   synchronous active-high; outputs forced to
//                     en_pc=en_if_id=flush_id_ex=1 while asserted
//   hz           slave modport of pipeline_stall_ctrl_if
//   stall_count  out  [31:0] stall cycle counter (STALL_STATS_EN only)
// Optional feature macro: STALL_STATS_EN.
// -----------------------------------------------------------------------------
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF   // must hold max(MULT_CYCLES, DIV_CYCLES)
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_stall_ctrl_if.slave  hz
`ifdef STALL_STATS_EN
  ,
  output logic [31:0]           stall_count
`endif
);

  // Operand 0 = rs, operand 1 = rt; both go through the same hazard check.
  logic [4:0] src_addr [2];
  logic [1:0] src_tuse [2];
  logic [1:0] src_stall;
  logic       stall_md;
  logic       stall;
  logic       md_busy_w;

  assign src_addr[0] = hz.rs_d;
  assign src_addr[1] = hz.rt_d;
  assign src_tuse[0] = hz.tuse_rs_d;
  assign src_tuse[1] = hz.tuse_rt_d;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign src_stall[gi] = gpr_hazard(src_addr[gi], src_tuse[gi],
                                        hz.dst_e, hz.tnew_e,
                                        hz.dst_m, hz.tnew_m);
    end
  endgenerate

  // A start in EX this cycle blocks an MD instruction in ID just like a busy
  // unit does; md_busy only rises the following cycle.
  assign stall_md = hz.md_use_d & (hz.md_start_e | md_busy_w);
  assign stall    = (|src_stall) | stall_md;

  assign hz.en_pc       = reset | ~stall;
  assign hz.en_if_id    = reset | ~stall;
  assign hz.flush_id_ex = reset | stall;
  assign hz.md_busy     = md_busy_w;

  md_busy_tracker #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_tracker (
    .clk      (clk),
    .reset    (reset),
    .md_start (hz.md_start_e),
    .md_div   (hz.md_div_e),
    .md_busy  (md_busy_w)
  );

`ifdef STALL_STATS_EN
  logic [31:0] stall_count_reg;

  // Free-running, wraps at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_reg <= '0;
    end else if (stall) begin
      stall_count_reg <= stall_count_reg + 32'd1;
    end
  end

  assign stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
// Directed bench for pipeline_stall_ctrl. Each step pushes the expected
// outputs (from a small behavioural model of the hazard rules and of the MD
// busy window) onto a scoreboard, then pops and compares mid-cycle.
// Honors STALL_STATS_EN for the stall_count port.
// -----------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;
  import pipeline_stall_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_stall_ctrl_if hz();
`ifdef STALL_STATS_EN
  logic [31:0] stall_count;
`endif

  pipeline_stall_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
`ifdef STALL_STATS_EN
    ,
    .stall_count (stall_count)
`endif
  );

  typedef struct {
    string       tag;
    logic [3:0]  outs;   // {en_pc, en_if_id, flush_id_ex, md_busy}
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          busy_left = 0;       // model: busy cycles still to come
  logic [31:0] cnt_model = 32'd0;

  // Reference RAW rule written from the operand's point of view.
  function automatic logic ref_raw(input logic [4:0] src, input logic [1:0] tuse);
    int need;
    need = int'(tuse);
    if (src == 5'd0) return 1'b0;
    if (src == hz.dst_e && int'(hz.tnew_e) > need) return 1'b1;
    if (src == hz.dst_m && int'(hz.tnew_m) > need) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic ref_stall();
    logic md;
    md = hz.md_use_d && (hz.md_start_e || busy_left > 0);
    return ref_raw(hz.rs_d, hz.tuse_rs_d) || ref_raw(hz.rt_d, hz.tuse_rt_d) || md;
  endfunction

  task automatic drive_idle();
    hz.rs_d = 5'd0;  hz.rt_d = 5'd0;
    hz.tuse_rs_d = TUSE_NONE; hz.tuse_rt_d = TUSE_NONE;
    hz.md_use_d = 1'b0;
    hz.dst_e = 5'd0; hz.tnew_e = 2'd0;
    hz.dst_m = 5'd0; hz.tnew_m = 2'd0;
    hz.md_start_e = 1'b0; hz.md_div_e = 1'b0;
  endtask

  task automatic check_out();
    exp_t       e;
    logic [3:0] act;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries expected >=1");
    end
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {hz.en_pc, hz.en_if_id, hz.flush_id_ex, hz.md_busy};
      assert (act === e.outs) else begin
        errors++;
        $error("FAIL %s: observed en_pc/en_if_id/flush/md_busy=%b expected %b", e.tag, act, e.outs);
      end
`ifdef STALL_STATS_EN
      checks++;
      assert (stall_count === e.cnt) else begin
        errors++;
        $error("FAIL %s_count: observed stall_count=%0d expected %0d", e.tag, stall_count, e.cnt);
      end
`endif
      $display("step %-16s outs=%b exp=%b", e.tag, act, e.outs);
    end
  endtask

  // One clock of stimulus: predict, compare mid-cycle, then advance model.
  task automatic step(input string tag);
    exp_t e;
    logic s;
    s      = ref_stall();
    e.tag  = tag;
    e.outs = reset ? {3'b111, busy_left > 0} : {~s, ~s, s, busy_left > 0};
    e.cnt  = cnt_model;
    sb.push_back(e);
    @(negedge clk);
    check_out();
    @(posedge clk);
    if (reset) begin
      busy_left = 0;
      cnt_model = 32'd0;
    end else begin
      if (s) cnt_model = cnt_model + 32'd1;
      if (busy_left > 0) busy_left--;
      else if (hz.md_start_e) busy_left = hz.md_div_e ? 10 : 5;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    @(posedge clk); #1;

    // 1. reset hold and idle
    step("rst_hold_a");
    step("rst_hold_b");
    reset = 1'b0;
    step("idle_a");
    step("idle_b");

    // 2. load-use on rs, then forwarded from MEM
    hz.dst_e = 5'd5; hz.tnew_e = TNEW_2; hz.rs_d = 5'd5; hz.tuse_rs_d = TUSE_1;
    step("lwuse_stall");
    hz.dst_e = 5'd0; hz.tnew_e = TNEW_0; hz.dst_m = 5'd5; hz.tnew_m = TNEW_1;
    step("lwuse_release");
    drive_idle();
    hz.rt_d = 5'd7; hz.tuse_rt_d = TUSE_0; hz.dst_e = 5'd7; hz.tnew_e = TNEW_1;
    step("rt_stall_e");
    hz.dst_e = 5'd0; hz.dst_m = 5'd7; hz.tnew_m = TNEW_1;
    step("rt_stall_m");
    hz.tuse_rt_d = TUSE_1;
    step("rt_tnew_eq_tuse");

    // 3. $0 and unused operand never stall
    drive_idle();
    hz.dst_e = 5'd0; hz.tnew_e = TNEW_2; hz.rs_d = 5'd0; hz.tuse_rs_d = TUSE_0;
    step("zero_reg");
    hz.rt_d = 5'd9; hz.dst_e = 5'd9; hz.tuse_rt_d = TUSE_NONE;
    step("tuse_none");
    // several causes at once still give a single stall
    hz.rs_d = 5'd9; hz.tuse_rs_d = TUSE_0; hz.tuse_rt_d = TUSE_0; hz.md_use_d = 1'b1;
    hz.md_start_e = 1'b1;
    step("multi_cause");
    drive_idle();
    for (int i = 0; i < 5; i++) step($sformatf("drain_%0d", i));

    // 4. mult: md_busy 5 cycles, MD consumer stalled start + 5, released 7th
    hz.md_start_e = 1'b1; hz.md_div_e = 1'b0; hz.md_use_d = 1'b1;
    step("mult_start");
    hz.md_start_e = 1'b0;
    for (int i = 1; i <= 6; i++) step($sformatf("mult_cyc%0d", i));
    drive_idle();

    // 5. div interrupted by reset on busy cycle 4
    hz.md_start_e = 1'b1; hz.md_div_e = 1'b1;
    step("div_start");
    hz.md_start_e = 1'b0; hz.md_div_e = 1'b0;
    for (int i = 1; i <= 3; i++) step($sformatf("div_busy%0d", i));
    reset = 1'b1;
    step("div_reset");
    reset = 1'b0;
    hz.md_use_d = 1'b1;
    step("div_after_rst_a");
    step("div_after_rst_b");
    drive_idle();

    // 6. stall statistics: 3 RAW stalls + 6 MD stall cycles
    reset = 1'b1;
    step("stats_reset");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hz.dst_e = 5'd12; hz.tnew_e = TNEW_2; hz.rs_d = 5'd12; hz.tuse_rs_d = TUSE_0;
      step($sformatf("stats_raw%0d", i));
      drive_idle();
      step($sformatf("stats_gap%0d", i));
    end
    hz.md_start_e = 1'b1; hz.md_use_d = 1'b1;
    step("stats_mult");
    hz.md_start_e = 1'b0;
    for (int i = 1; i <= 6; i++) step($sformatf("stats_md%0d", i));
    drive_idle();
    @(negedge clk);
`ifdef STALL_STATS_EN
    checks++;
    assert (stall_count === 32'd9) else begin
      errors++;
      $error("FAIL stats_total: observed stall_count=%0d expected 9", stall_count);
    end
    $display("step %-16s stall_count=%0d exp=9", "stats_total", stall_count);
`endif
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
`ifdef STALL_STATS_EN
    checks++;
    assert (stall_count === 32'd0) else begin
      errors++;
      $error("FAIL stats_cleared: observed stall_count=%0d expected 0", stall_count);
    end
    $display("step %-16s stall_count=%0d exp=0", "stats_cleared", stall_count);
`endif
    checks++;
    assert (hz.md_busy === 1'b0 && hz.flush_id_ex === 1'b0) else begin
      errors++;
      $error("FAIL final_idle: observed md_busy=%b flush=%b expected 0/0", hz.md_busy, hz.flush_id_ex);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
